// File: rtl/alu_spi_pkg.sv
// Shared types and frame layout for the SPI front end of the 4-bit ALU controller.
package alu_spi_pkg;

    localparam int DATA_W = 4;
    localparam int FRAME_W = 16;

    localparam int OP_MSB = 15;
    localparam int OP_LSB = 14;
    localparam int A_MSB  = 13;
    localparam int A_LSB  = 10;
    localparam int B_MSB  = 9;
    localparam int B_LSB  = 6;

    typedef enum logic [1:0] {
        OP_AND = 2'b00,
        OP_OR  = 2'b01,
        OP_ADD = 2'b10,
        OP_SUB = 2'b11
    } alu_op_t;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        SHIFT = 2'b01,
        EXEC  = 2'b10,
        CAPT  = 2'b11
    } state_t;

    // Status word returned to the master during the following frame.
    function automatic logic [FRAME_W-1:0] miso_word(
        input logic [DATA_W-1:0] result,
        input logic [3:0]        cnt,
        input logic              err
    );
        return {result, cnt, err, 7'b0};
    endfunction

endpackage

// File: rtl/alu_spi_slave_sync_edge.sv
// Multi-flop pin synchronizer with single-cycle rise/fall pulses on the synchronized level.
module spi_sync_edge #(
    parameter int   SYNC_STAGES = 2,
    parameter logic RST_VAL     = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic dout,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= {SYNC_STAGES{RST_VAL}};
            prev_q <= RST_VAL;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], din};
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign dout = sync_q[SYNC_STAGES-1];
    assign rise = dout & ~prev_q;
    assign fall = ~dout & prev_q;

endmodule

// File: rtl/alu_spi_slave.sv
// SPI mode-0 slave: receives 16-bit ALU command frames, drives the ALU, returns the result next frame.
module alu_spi_slave
    import alu_spi_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int FRAME_BITS  = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        spi_sclk,
    input  logic        spi_cs_n,
    input  logic        spi_mosi,
    output logic        spi_miso,
    output logic [1:0]  alu_op,
    output logic [3:0]  alu_a,
    output logic [3:0]  alu_b,
    input  logic [3:0]  alu_result,
    output logic        frame_done,
    output logic        frame_err
);

    localparam logic [4:0] CNT_FULL = 5'(FRAME_BITS);
    localparam logic [4:0] CNT_OVR  = 5'(FRAME_BITS + 1);

    logic sclk_s, sclk_rise, sclk_fall;
    logic cs_n_s, cs_rise, cs_fall;
    logic [SYNC_STAGES-1:0] mosi_sync;
    logic mosi_s;

    state_t              state;
    logic [FRAME_W-1:0]  rx_shift;
    logic [FRAME_W-1:0]  tx_shift;
    logic [4:0]          bit_cnt;
    logic [DATA_W-1:0]   last_result;
    logic [3:0]          frame_cnt;
    logic                err_flag;
    logic                cs_pend;
    alu_op_t             op_field;

    spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sclk_sync (
        .clk  (clk),
        .rst  (rst),
        .din  (spi_sclk),
        .dout (sclk_s),
        .rise (sclk_rise),
        .fall (sclk_fall)
    );

    // cs_n resets high so leaving reset never looks like a select.
    spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_cs_sync (
        .clk  (clk),
        .rst  (rst),
        .din  (spi_cs_n),
        .dout (cs_n_s),
        .rise (cs_rise),
        .fall (cs_fall)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mosi_sync <= '0;
        end else begin
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], spi_mosi};
        end
    end

    assign mosi_s   = mosi_sync[SYNC_STAGES-1];
    assign op_field = alu_op_t'(rx_shift[OP_MSB:OP_LSB]);
    assign spi_miso = (state == SHIFT) & ~cs_n_s & tx_shift[FRAME_W-1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            rx_shift    <= '0;
            tx_shift    <= '0;
            bit_cnt     <= '0;
            last_result <= '0;
            frame_cnt   <= '0;
            err_flag    <= 1'b0;
            cs_pend     <= 1'b0;
            alu_op      <= '0;
            alu_a       <= '0;
            alu_b       <= '0;
            frame_done  <= 1'b0;
            frame_err   <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            frame_err  <= 1'b0;
            case (state)
                IDLE: begin
                    if (cs_fall || cs_pend) begin
                        tx_shift <= miso_word(last_result, frame_cnt, err_flag);
                        err_flag <= 1'b0;
                        bit_cnt  <= '0;
                        cs_pend  <= 1'b0;
                        state    <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (cs_rise) begin
                        if (bit_cnt == CNT_FULL) begin
                            state <= EXEC;
                        end else begin
                            frame_err <= 1'b1;
                            err_flag  <= 1'b1;
                            state     <= IDLE;
                        end
                    end else if (!cs_n_s) begin
                        if (sclk_rise) begin
                            rx_shift <= {rx_shift[FRAME_W-2:0], mosi_s};
                            if (bit_cnt != CNT_OVR) begin
                                bit_cnt <= bit_cnt + 5'd1;
                            end
                        end
                        if (sclk_fall) begin
                            tx_shift <= {tx_shift[FRAME_W-2:0], 1'b0};
                        end
                    end
                end
                EXEC: begin
                    alu_op <= op_field;
                    alu_a  <= rx_shift[A_MSB:A_LSB];
                    alu_b  <= rx_shift[B_MSB:B_LSB];
                    if (cs_fall) begin
                        cs_pend <= 1'b1;
                    end
                    state <= CAPT;
                end
                CAPT: begin
                    last_result <= alu_result;
                    frame_cnt   <= frame_cnt + 4'd1;
                    frame_done  <= 1'b1;
                    if (cs_fall) begin
                        cs_pend <= 1'b1;
                    end
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
